// File: rtl/leb128_decoder.sv
// rtl/leb128_decoder.sv - streaming LEB128 immediate decoder (signed/unsigned, overlong detection)
module leb128_decoder #(
    parameter int WIDTH     = 64,
    parameter int MAX_BYTES = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    output logic [WIDTH-1:0] out_value,
    output logic [3:0]       out_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             error
);

    // Payload bits of the last permitted byte that still land inside WIDTH.
    localparam int         U       = WIDTH - 7 * (MAX_BYTES - 1);
    localparam logic [6:0] HI_MASK = 7'(7'h7f << U);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE, ERR} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] acc, acc_n, value_n;
    logic [3:0]       count, count_n, len_n;
    logic             sgn, sgn_n;

    logic             take, sgn_eff, last, final_ok;
    logic [3:0]       count_inc;
    logic [6:0]       sh_cur, sh_next;
    logic [WIDTH-1:0] acc_or, ext;

    assign in_ready  = (state == IDLE) || (state == ACCUM);
    assign out_valid = (state == DONE);
    assign error     = (state == ERR);

    assign take      = in_valid && in_ready;
    assign count_inc = count + 4'd1;
    assign sh_cur    = 7'(count) * 7'd7;
    assign sh_next   = 7'(count_inc) * 7'd7;
    assign sgn_eff   = (state == IDLE) ? is_signed : sgn;
    assign acc_or    = ((state == IDLE) ? '0 : acc) | (WIDTH'(in_byte[6:0]) << sh_cur);
    // Shift amounts at or beyond WIDTH yield zero, so a full-length value gets no extension.
    assign ext       = (sgn_eff && in_byte[6]) ? ({WIDTH{1'b1}} << sh_next) : '0;
    assign last      = (count_inc == 4'(MAX_BYTES));
    assign final_ok  = sgn_eff ? ((in_byte[6:0] & HI_MASK) == (in_byte[U-1] ? HI_MASK : 7'd0))
                               : ((in_byte[6:0] & HI_MASK) == 7'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            acc       <= '0;
            count     <= '0;
            sgn       <= 1'b0;
            out_value <= '0;
            out_len   <= '0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            count     <= count_n;
            sgn       <= sgn_n;
            out_value <= value_n;
            out_len   <= len_n;
        end
    end

    always_comb begin
        state_n = state;
        acc_n   = acc;
        count_n = count;
        sgn_n   = sgn;
        value_n = out_value;
        len_n   = out_len;
        case (state)
            IDLE, ACCUM: begin
                if (take) begin
                    acc_n   = acc_or;
                    count_n = count_inc;
                    sgn_n   = sgn_eff;
                    if (in_byte[7]) begin
                        state_n = last ? ERR : ACCUM;
                    end else if (last && !final_ok) begin
                        state_n = ERR;
                    end else begin
                        state_n = DONE;
                        value_n = acc_or | ext;
                        len_n   = count_inc;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                    acc_n   = '0;
                    count_n = '0;
                end
            end
            default: state_n = ERR;
        endcase
    end

endmodule

// File: tb/tb_leb128_decoder.sv
// tb/tb_leb128_decoder.sv - randomized self-checking bench for leb128_decoder
module tb_leb128_decoder;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        is_signed = 1'b0;
    logic [63:0] out_value;
    logic [3:0]  out_len;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        error;

    int checks = 0;
    int failures = 0;

    leb128_decoder #(.WIDTH(64), .MAX_BYTES(10)) dut (
        .clk(clk), .reset(reset), .in_byte(in_byte), .in_valid(in_valid),
        .in_ready(in_ready), .is_signed(is_signed), .out_value(out_value),
        .out_len(out_len), .out_valid(out_valid), .out_ready(out_ready), .error(error)
    );

    always #5 clk = ~clk;

    // Reference: accumulate in a wide integer, then ask whether the result fits 64 bits.
    task automatic model(input bq_t q, input bit s, output logic [63:0] v,
                         output logic [3:0] len, output bit err);
        logic [127:0] a;
        int n;
        a = '0; n = 0; err = 0;
        foreach (q[i]) begin
            a = a | (128'(q[i][6:0]) << (7 * i));
            n = i + 1;
            if (!q[i][7]) break;
            if (n == 10) err = 1;
        end
        if (s && a[7*n-1]) a = a | ({128{1'b1}} << (7 * n));
        if (!s && a[127:64] != 0) err = 1;
        if (s && !(a[127:63] == 0 || a[127:63] == {65{1'b1}})) err = 1;
        v = a[63:0];
        len = 4'(n);
    endtask

    task automatic put_byte(input logic [7:0] b, input logic s);
        int n;
        n = 0;
        in_byte = b; in_valid = 1'b1; is_signed = s;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL put_byte_timeout in_ready=%0b required=1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Drives one encoding, samples outputs after the last transfer, then completes the handshake.
    task automatic decode(input bq_t q, input bit s, output logic [63:0] v, output logic [3:0] l,
                          output logic ov, output logic er, output logic ir, output logic ov_after);
        foreach (q[i]) put_byte(q[i], s);
        v = out_value; l = out_len; ov = out_valid; er = error; ir = in_ready;
        ov_after = 1'b0;
        if (ov) begin
            out_ready = 1'b1;
            @(negedge clk);
            ov_after = out_valid;
            out_ready = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_value !== 64'd0 || out_len !== 4'd0 || out_valid !== 1'b0 || error !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state value=%h len=%0d ov=%0b err=%0b ir=%0b required 0/0/0/0/1",
                     out_value, out_len, out_valid, error, in_ready);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        bq_t q[6];
        bit  s[6];
        logic [63:0] ev[6];
        logic [3:0]  el[6];
        logic [63:0] v; logic [3:0] l; logic ov, er, ir, ova;
        q[0] = '{8'hE5, 8'h8E, 8'h26}; s[0] = 0; ev[0] = 64'h98765;               el[0] = 3;
        q[1] = '{8'hC0, 8'hBB, 8'h78}; s[1] = 1; ev[1] = 64'hFFFF_FFFF_FFFE_1DC0; el[1] = 3;
        q[2] = '{8'h7F};               s[2] = 1; ev[2] = 64'hFFFF_FFFF_FFFF_FFFF; el[2] = 1;
        q[3] = '{8'h7F};               s[3] = 0; ev[3] = 64'd127;                 el[3] = 1;
        q[4] = '{8'h80, 8'h00};        s[4] = 0; ev[4] = 64'd0;                   el[4] = 2;
        q[5] = '{8'hFF, 8'h00};        s[5] = 1; ev[5] = 64'd127;                 el[5] = 2;
        for (int i = 0; i < 6; i++) begin
            decode(q[i], s[i], v, l, ov, er, ir, ova);
            checks++;
            if (ov !== 1'b1 || v !== ev[i] || l !== el[i] || er !== 1'b0 || ir !== 1'b0 || ova !== 1'b0) begin
                failures++;
                $display("FAIL directed_%0d value=%h len=%0d ov=%0b err=%0b ir=%0b ov_after=%0b required value=%h len=%0d",
                         i, v, l, ov, er, ir, ova, ev[i], el[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        put_byte(8'h02, 1'b0);
        in_byte = 8'h03; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_value !== 64'd2 || out_len !== 4'd1 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL backpressure_hold_%0d ov=%0b value=%h len=%0d ir=%0b required 1/2/1/0",
                         i, out_valid, out_value, out_len, in_ready);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL backpressure_bubble ov=%0b ir=%0b required 0/1", out_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_value !== 64'd3 || out_len !== 4'd1) begin
            failures++;
            $display("FAIL backpressure_next ov=%0b value=%h len=%0d required 1/3/1", out_valid, out_value, out_len);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_overlong();
        bit seen_ov;
        seen_ov = 0;
        for (int i = 0; i < 10; i++) begin
            put_byte(8'h80, 1'b0);
            if (out_valid) seen_ov = 1;
        end
        in_byte = 8'h01; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (error !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 || seen_ov) begin
                failures++;
                $display("FAIL overlong_sticky_%0d err=%0b ir=%0b ov=%0b seen_ov=%0b required 1/0/0/0",
                         i, error, in_ready, out_valid, seen_ov);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b0;
        do_reset();
        checks++;
        if (error !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL overlong_clear err=%0b ir=%0b required 0/1", error, in_ready);
        end
    endtask

    task automatic test_final_byte();
        bq_t q;
        logic [63:0] v; logic [3:0] l; logic ov, er, ir, ova;
        logic [7:0] fill[4];
        logic [7:0] fin[4];
        bit s[4];
        bit eerr[4];
        logic [63:0] ev[4];
        fill = '{8'hFF, 8'hFF, 8'h80, 8'h80};
        fin  = '{8'h01, 8'h03, 8'h7F, 8'h3F};
        s    = '{0, 0, 1, 1};
        eerr = '{0, 1, 0, 1};
        ev   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h8000_0000_0000_0000, 64'd0};
        for (int k = 0; k < 4; k++) begin
            q = {};
            for (int i = 0; i < 9; i++) q.push_back(fill[k]);
            q.push_back(fin[k]);
            decode(q, s[k], v, l, ov, er, ir, ova);
            checks++;
            if (eerr[k]) begin
                if (er !== 1'b1 || ov !== 1'b0 || ir !== 1'b0) begin
                    failures++;
                    $display("FAIL final_byte_%0d err=%0b ov=%0b ir=%0b required 1/0/0", k, er, ov, ir);
                end
                do_reset();
            end else if (ov !== 1'b1 || er !== 1'b0 || v !== ev[k] || l !== 4'd10) begin
                failures++;
                $display("FAIL final_byte_%0d ov=%0b err=%0b value=%h len=%0d required 1/0/%h/10",
                         k, ov, er, v, l, ev[k]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] v; logic [3:0] l; logic ov, er, ir, ova;
        put_byte(8'h81, 1'b0);
        put_byte(8'h80, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (out_value !== 64'd0 || out_len !== 4'd0 || out_valid !== 1'b0 || error !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_outputs value=%h len=%0d ov=%0b err=%0b required all 0",
                     out_value, out_len, out_valid, error);
        end
        reset = 1'b1;
        decode('{8'h05}, 1'b0, v, l, ov, er, ir, ova);
        checks++;
        if (ov !== 1'b1 || v !== 64'd5 || l !== 4'd1 || er !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_next ov=%0b value=%h len=%0d err=%0b required 1/5/1/0", ov, v, l, er);
        end
    endtask

    task automatic test_random();
        bq_t q;
        bit s, eerr;
        int n;
        logic [63:0] ev; logic [3:0] el;
        logic [63:0] v; logic [3:0] l; logic ov, er, ir, ova;
        for (int t = 0; t < 300; t++) begin
            s = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 10);
            q = {};
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                b[7] = (i != n - 1);
                if (i == 9 && $urandom_range(0, 1) == 1)
                    b[6:1] = s ? {6{b[0]}} : 6'd0;
                q.push_back(b);
            end
            model(q, s, ev, el, eerr);
            decode(q, s, v, l, ov, er, ir, ova);
            checks++;
            if (eerr) begin
                if (er !== 1'b1 || ov !== 1'b0) begin
                    failures++;
                    $display("FAIL random_%0d err=%0b ov=%0b required err=1 ov=0", t, er, ov);
                end
                do_reset();
            end else if (ov !== 1'b1 || er !== 1'b0 || v !== ev || l !== el || ova !== 1'b0) begin
                failures++;
                $display("FAIL random_%0d s=%0b ov=%0b err=%0b value=%h len=%0d ov_after=%0b required value=%h len=%0d",
                         t, s, ov, er, v, l, ova, ev, el);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_overlong();
        test_final_byte();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/leb128_decoder.md
Name: leb128_decoder

Overview:
Streaming LEB128 decoder feeding the cpu execute stage with immediates (i32.const/i64.const operands, local/global indices, branch depths, memarg offsets) fetched byte-by-byte from ROM. Accepts one byte per cycle over a valid/ready handshake and accumulates up to MAX_BYTES bytes. Emits a full-width sign- or zero-extended value with its encoded length. Flags malformed or overlong encodings so the cpu can raise a trap.

Parameters:
WIDTH, 64, decoded value width (32 or 64)
MAX_BYTES, 10, max encoded length; must equal ceil(WIDTH/7) (5 for WIDTH=32)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-low reset
in_byte  input  8  encoded byte from fetch
in_valid  input  1  in_byte valid
in_ready  output  1  decoder accepts in_byte this cycle
is_signed  input  1  signed (sLEB128) when 1; sampled with the first byte of each value
out_value  output  WIDTH  decoded value, sign/zero extended
out_len  output  4  number of bytes consumed (1..MAX_BYTES)
out_valid  output  1  out_value/out_len valid
out_ready  input  1  consumer takes result
error  output  1  malformed/overlong encoding; sticky

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, accumulator=0, byte count=0, out_value=0, out_len=0, out_valid=0, error=0. Reset mid-value discards all partial state; no output is produced for the aborted value.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE and ERROR. A byte transfers on posedge with in_valid & in_ready.
- States:
  - IDLE: on transfer, latch is_signed, acc = byte[6:0], count=1, shift=7. If byte[7]=0 → DONE, else → ACCUM.
  - ACCUM: on transfer, acc |= byte[6:0] << shift, count++, shift += 7. byte[7]=0 → DONE. byte[7]=1 with count+1 == MAX_BYTES → ERROR.
  - DONE: out_valid=1; out_value/out_len stable. On out_ready → IDLE at the next edge; acc and count cleared.
  - ERROR: error=1, out_valid=0, in_ready=0; left only by reset.
- Latency: out_valid rises on the edge that accepts the terminating byte (registered output, visible the cycle after the transfer). The handshake leaves one bubble cycle between values: no byte is accepted in the cycle out_ready is seen.
- Sign extension (signed mode): if the terminating byte has bit6=1 and shift < WIDTH, bits [WIDTH-1:shift] are set to 1. Unsigned mode zero-extends.
- Final-byte check: when count == MAX_BYTES, let U = WIDTH − 7·(MAX_BYTES−1) (1 for 64, 4 for 32).
  - Unsigned: byte[6:U] must be 0.
  - Signed: byte[6:U] must all equal byte[U−1].
  - A violation → ERROR instead of DONE, and no out_valid.
- Non-minimal encodings (e.g. 0x80 0x00) are legal and decode normally with out_len reflecting bytes consumed.
- in_valid while in_ready=0 is ignored; the byte is not consumed, and the source holds it.
- out_ready while out_valid=0 has no effect.

Test Plan:
- Unsigned 0xE5,0x8E,0x26 back-to-back, out_ready=1 → out_value=624485 (0x98765), out_len=3, out_valid high one cycle, error=0.
- Signed 0xC0,0xBB,0x78 → out_value=0xFFFF_FFFF_FFFE_1DC0 (−123456), out_len=3; then single byte 0x7F signed → 0xFFFF_FFFF_FFFF_FFFF, unsigned → 127, each out_len=1.
- Backpressure: decode 0x02 with out_ready=0 for 5 cycles → out_valid, out_value=2, out_len=1 held; in_ready=0 throughout; next value accepted only after the out_ready cycle plus one.
- Overlong: ten bytes 0x80 → ERROR on the 10th, error=1 sticky, in_ready=0, out_valid never asserts; reset low one cycle clears error, in_ready=1.
- Final-byte checks (WIDTH=64): unsigned 0xFF×9,0x01 → 0xFFFF_FFFF_FFFF_FFFF, len=10; unsigned 0xFF×9,0x03 → error; signed 0x80×9,0x7F → 0x8000_0000_0000_0000; signed 0x80×9,0x3F → error.
- Reset mid-value: accept 0x81,0x80, assert reset → all outputs 0; then 0x05 → out_value=5, out_len=1.
